// File: rtl/uart_frame_scheduler.sv
// Frame-rate scheduler between the drive-mode engines and the UART link: selects the move
// command once per frame, stretches beacon requests with req/ack, and debounces detector bits.
module uart_frame_scheduler #(
    parameter int FRAME_TICKS   = 1_000_000,
    parameter int BEACON_FRAMES = 4,
    parameter int DET_STABLE    = 3
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [1:0] global_state,
    input  logic       power,
    input  logic [3:0] man_move,
    input  logic [3:0] semi_move,
    input  logic [3:0] auto_move,
    input  logic       pl_req,
    input  logic       de_req,
    output logic       pl_ack,
    output logic       de_ack,
    input  logic [7:0] rec,
    output logic [7:0] data_in,
    output logic       frame_tick,
    output logic [3:0] detector,
    output logic       beacon_busy
);

    localparam int CNT_W = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam int K_W   = $clog2(BEACON_FRAMES + 1);
    localparam int RUN_W = $clog2(DET_STABLE + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_TICKS - 1);
    localparam logic [K_W-1:0]   K_LOAD   = K_W'(BEACON_FRAMES);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DET_STABLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLACE,
        S_DESTROY,
        S_RELEASE
    } state_t;

    logic [CNT_W-1:0] cnt;
    logic [3:0]       move_q;
    logic [1:0]       last_mode;
    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             served_pl_q, served_pl_d;
    logic             pl_ack_d, de_ack_d;
    logic             mode_ok;
    logic [RUN_W-1:0] run_q [4];
    logic             unused_rec;

    assign unused_rec = ^rec[7:4];

    assign frame_tick  = (cnt == CNT_MAX);
    assign mode_ok     = (global_state == 2'b11) && power;
    assign beacon_busy = (state_q != S_IDLE);
    assign data_in     = {2'b10, state_q == S_DESTROY, state_q == S_PLACE, move_q};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (frame_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A mode change always costs one stop frame so the car halts before a new engine drives it.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            move_q    <= 4'b0000;
            last_mode <= 2'b00;
        end else if (frame_tick) begin
            if (!power) begin
                move_q <= 4'b0000;
            end else if (global_state != last_mode) begin
                move_q    <= 4'b0000;
                last_mode <= global_state;
            end else begin
                case (global_state)
                    2'b00:   move_q <= man_move;
                    2'b11:   move_q <= auto_move;
                    default: move_q <= semi_move;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            served_pl_q <= 1'b0;
            pl_ack      <= 1'b0;
            de_ack      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            served_pl_q <= served_pl_d;
            pl_ack      <= pl_ack_d;
            de_ack      <= de_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        served_pl_d = served_pl_q;
        pl_ack_d    = 1'b0;
        de_ack_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_tick && mode_ok && (pl_req || de_req)) begin
                    state_d     = pl_req ? S_PLACE : S_DESTROY;
                    served_pl_d = pl_req;
                    k_d         = K_LOAD;
                end
            end
            S_PLACE, S_DESTROY: begin
                if (frame_tick) begin
                    if (!mode_ok) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q - 1'b1;
                        if (k_q == K_LAST) begin
                            state_d  = S_RELEASE;
                            pl_ack_d = served_pl_q;
                            de_ack_d = !served_pl_q;
                        end
                    end
                end
            end
            S_RELEASE: begin
                // Hold off until the engine withdraws the request it was served for.
                if (served_pl_q ? !pl_req : !de_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            detector <= 4'b0000;
            for (int i = 0; i < 4; i++) run_q[i] <= '0;
        end else if (frame_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (rec[i] == detector[i]) begin
                    run_q[i] <= '0;
                end else if (run_q[i] == RUN_LAST) begin
                    detector[i] <= rec[i];
                    run_q[i]    <= '0;
                end else begin
                    run_q[i] <= run_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: per-frame expectations are queued as stimulus is
// applied and popped when the frame boundary updates the outputs.
module tb_uart_frame_scheduler;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] global_state = 2'b00;
    logic       power = 1'b1;
    logic [3:0] man_move = 4'b0101;
    logic [3:0] semi_move = 4'b0111;
    logic [3:0] auto_move = 4'b0010;
    logic       pl_req = 1'b0;
    logic       de_req = 1'b0;
    logic       pl_ack, de_ack;
    logic [7:0] rec = 8'h00;
    logic [7:0] data_in;
    logic       frame_tick;
    logic [3:0] detector;
    logic       beacon_busy;

    typedef struct packed {
        logic [7:0] d;
        logic       busy;
        logic       pa;
        logic       da;
        logic [3:0] det;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   tick_cyc = 0;

    uart_frame_scheduler #(
        .FRAME_TICKS  (4),
        .BEACON_FRAMES(2),
        .DET_STABLE   (3)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .global_state(global_state),
        .power       (power),
        .man_move    (man_move),
        .semi_move   (semi_move),
        .auto_move   (auto_move),
        .pl_req      (pl_req),
        .de_req      (de_req),
        .pl_ack      (pl_ack),
        .de_ack      (de_ack),
        .rec         (rec),
        .data_in     (data_in),
        .frame_tick  (frame_tick),
        .detector    (detector),
        .beacon_busy (beacon_busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the frame_tick cycle, then steps to just after the edge that ends it.
    task automatic wait_tick();
        int n = 0;
        while (!frame_tick && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        check("tick_timeout", {7'd0, n < 40}, 8'd1);
        tick_cyc = cyc;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic busy,
                         input logic pa, input logic da, input logic [3:0] det);
        exp_t e;
        sb.push_back({d, busy, pa, da, det});
        wait_tick();
        e = sb.pop_front();
        check({tag, "_data"}, data_in, e.d);
        check({tag, "_busy"}, {7'd0, beacon_busy}, {7'd0, e.busy});
        check({tag, "_plack"}, {7'd0, pl_ack}, {7'd0, e.pa});
        check({tag, "_deack"}, {7'd0, de_ack}, {7'd0, e.da});
        check({tag, "_det"}, {4'd0, detector}, {4'd0, e.det});
    endtask

    task automatic one_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_data", data_in, 8'h80);
        check("rst_tick", {7'd0, frame_tick}, 8'd0);
        check("rst_acks", {6'd0, pl_ack, de_ack}, 8'd0);
        check("rst_det", {4'd0, detector}, 8'd0);
        check("rst_busy", {7'd0, beacon_busy}, 8'd0);

        @(negedge sys_clk);
        rst = 1'b0;

        // Reset/idle: mode 00 matches reset last_mode, so no stop frame.
        frame("t1", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        check("first_tick_cycle", 8'(tick_cyc), 8'd3);
        frame("t2", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        check("second_tick_cycle", 8'(tick_cyc), 8'd7);

        // Mode switch to auto: one stop frame, then auto_move.
        global_state = 2'b11;
        frame("sw_stop", 8'h80, 1'b0, 1'b0, 1'b0, 4'h0);
        frame("sw_auto", 8'h82, 1'b0, 1'b0, 1'b0, 4'h0);
        power = 1'b0;
        frame("pwr_off", 8'h80, 1'b0, 1'b0, 1'b0, 4'h0);
        power = 1'b1;
        frame("pwr_on", 8'h82, 1'b0, 1'b0, 1'b0, 4'h0);

        // Beacon place: two frames of pl_bit, then a one-cycle ack.
        pl_req = 1'b1;
        frame("pl_f1", 8'h92, 1'b1, 1'b0, 1'b0, 4'h0);
        frame("pl_f2", 8'h92, 1'b1, 1'b0, 1'b0, 4'h0);
        frame("pl_done", 8'h82, 1'b1, 1'b1, 1'b0, 4'h0);
        one_cycle();
        check("pl_ack_single", {7'd0, pl_ack}, 8'd0);
        frame("pl_release", 8'h82, 1'b1, 1'b0, 1'b0, 4'h0);
        pl_req = 1'b0;
        one_cycle();
        check("pl_release_exit", {7'd0, beacon_busy}, 8'd0);

        // Simultaneous requests: place first, destroy once place is released.
        pl_req = 1'b1;
        de_req = 1'b1;
        frame("both_f1", 8'h92, 1'b1, 1'b0, 1'b0, 4'h0);
        frame("both_f2", 8'h92, 1'b1, 1'b0, 1'b0, 4'h0);
        frame("both_pldone", 8'h82, 1'b1, 1'b1, 1'b0, 4'h0);
        pl_req = 1'b0;
        frame("de_f1", 8'hA2, 1'b1, 1'b0, 1'b0, 4'h0);
        frame("de_f2", 8'hA2, 1'b1, 1'b0, 1'b0, 4'h0);
        frame("de_done", 8'h82, 1'b1, 1'b0, 1'b1, 4'h0);
        de_req = 1'b0;
        one_cycle();
        check("de_ack_single", {7'd0, de_ack}, 8'd0);
        check("de_release_exit", {7'd0, beacon_busy}, 8'd0);

        // Abort: leaving auto mode during PLACE clears the bit with no ack.
        pl_req = 1'b1;
        frame("ab_f1", 8'h92, 1'b1, 1'b0, 1'b0, 4'h0);
        global_state = 2'b00;
        frame("ab_abort", 8'h80, 1'b0, 1'b0, 1'b0, 4'h0);
        one_cycle();
        check("ab_no_ack", {6'd0, pl_ack, de_ack}, 8'd0);
        pl_req = 1'b0;
        frame("ab_manual", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);

        // Detector debounce: 1,1,0 rejected; 1,1,1 accepted on the third frame.
        rec = 8'hF1;
        frame("det_a1", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        frame("det_a2", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        rec = 8'h00;
        frame("det_a3", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        rec = 8'h01;
        frame("det_b1", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        frame("det_b2", 8'h85, 1'b0, 1'b0, 1'b0, 4'h0);
        frame("det_b3", 8'h85, 1'b0, 1'b0, 1'b0, 4'h1);

        // Mid-operation reset while a beacon is active.
        global_state = 2'b11;
        pl_req = 1'b1;
        frame("mr_place", 8'h90, 1'b1, 1'b0, 1'b0, 4'h1);
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        check("mr_data", data_in, 8'h80);
        check("mr_busy", {7'd0, beacon_busy}, 8'd0);
        check("mr_det", {4'd0, detector}, 8'd0);
        check("mr_acks", {6'd0, pl_ack, de_ack}, 8'd0);
        check("mr_tick", {7'd0, frame_tick}, 8'd0);
        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
